// File: rtl/ksa_add_sched_pkg.sv
// Shared constants and state encoding for the two-requester multi-word adder
// scheduler built around a single 16-bit Kogge-Stone slice.
package ksa_add_sched_pkg;

  localparam int SLICE_W = 16;
  localparam int ID_W    = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ksa_add_sched_if.sv
// Request/response bundle between the arithmetic clients (master) and the
// adder scheduler (slave); requester i owns bits [i*W +: W] of req_a/req_b.
interface ksa_add_sched_if #(
  parameter int WORDS = 4
);
  import ksa_add_sched_pkg::*;

  localparam int W = SLICE_W * WORDS;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [W-1:0]    resp_sum;
  logic            resp_cout;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

endinterface

// File: rtl/ksa_add_sched_ksa16_ci.sv
// 16-bit Kogge-Stone adder (ksa16) and the carry-in slice built from two of
// them (ksa16_ci): a+b first, then that sum plus cin.
module ksa16
  import ksa_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g, p, gn, pn;

  // NOTE: every variable gets a full default before the loops so no path
  // leaves a bit unassigned, which would otherwise infer a latch.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    // log2(16) = 4 prefix levels, span doubling each level
    for (int l = 0; l < 4; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < SLICE_W; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    sum  = (a ^ b) ^ {g[SLICE_W-2:0], 1'b0};
    cout = g[SLICE_W-1];
  end

endmodule

module ksa16_ci
  import ksa_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] s0;
  logic               c0, c1;

  ksa16 u_add_ab  (.a(a),  .b(b),                        .sum(s0),  .cout(c0));
  ksa16 u_add_cin (.a(s0), .b({{(SLICE_W-1){1'b0}}, cin}), .sum(sum), .cout(c1));

  // at most one of the two stages can carry out
  assign cout = c0 | c1;

endmodule

// File: rtl/ksa_add_sched.sv
// Round-robin scheduler sharing one 16-bit Kogge-Stone slice between two
// requesters; each op is added LSW first, one word per cycle.
module ksa_add_sched
  import ksa_add_sched_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  ksa_add_sched_if.slave bus,
  output logic           busy
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] RUN  = S_RUN;
  localparam logic [1:0] DONE = S_DONE;

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       op_a, op_b, sum_q;
  logic               cout_q;

  logic [ID_W-1:0]    grant;
  logic               accept;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;

  // a lone requester wins outright; a tie goes to rr_ptr
  always_comb begin
    grant = rr_ptr;
    if (bus.req_valid == 2'b01)      grant = 1'b0;
    else if (bus.req_valid == 2'b10) grant = 1'b1;
  end

  assign bus.req_ready = (state == IDLE && bus.req_valid != 2'b00) ? {grant, ~grant} : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);

  ksa16_ci u_slice (
    .a    (op_a[int'(idx)*SLICE_W +: SLICE_W]),
    .b    (op_b[int'(idx)*SLICE_W +: SLICE_W]),
    .cin  (carry),
    .sum  (slice_s),
    .cout (slice_c)
  );

  // NOTE: operands are only read in RUN after being loaded on accept, so
  // their reset value is never observed and they sit outside the reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      op_a <= bus.req_a[int'(grant)*W +: W];
      op_b <= bus.req_b[int'(grant)*W +: W];
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q  <= grant;
            carry <= 1'b0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx)*SLICE_W +: SLICE_W] <= slice_s;
          carry <= slice_c;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout_q <= slice_c;
            state  <= DONE;
          end
        end
        DONE: begin
          // the winner yields priority only once its result is taken
          if (bus.resp_ready) begin
            rr_ptr <= ~id_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = (state == DONE);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_cout  = cout_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_ksa_add_sched.sv
// Directed-vector and sequence bench for ksa_add_sched (WORDS=4 and WORDS=1).
module tb_ksa_add_sched;

  logic clk = 1'b0;
  logic rst;
  logic busy4, busy1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   both_rdy = 0;
  logic exp_rr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ksa_add_sched_if #(.WORDS(4)) bus4 ();
  ksa_add_sched_if #(.WORDS(1)) bus1 ();

  ksa_add_sched #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));
  ksa_add_sched #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

  always @(negedge clk) if (bus4.req_ready == 2'b11) both_rdy <= both_rdy + 1;

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready4(input logic id);
    int n = 0;
    while (!bus4.req_ready[id] && n < 50) begin step(); n++; end
  endtask

  task automatic wait_resp4();
    int n = 0;
    while (!bus4.resp_valid && n < 50) begin step(); n++; end
  endtask

  // single requester op with resp_ready high; checks latency and result
  task automatic run_op(input string tag, input logic id, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_sum, input logic exp_cout);
    int t0;
    bus4.req_a = '0;
    bus4.req_b = '0;
    bus4.req_a[int'(id)*64 +: 64] = a;
    bus4.req_b[int'(id)*64 +: 64] = b;
    bus4.req_valid     = 2'b00;
    bus4.req_valid[id] = 1'b1;
    bus4.resp_ready    = 1'b1;
    #1;
    wait_ready4(id);
    check({tag, "_hs"}, 64'(bus4.req_ready), id ? 64'd2 : 64'd1);
    t0 = cyc;
    step();
    bus4.req_valid = 2'b00;
    bus4.req_a     = ~bus4.req_a;
    bus4.req_b     = ~bus4.req_b;
    wait_resp4();
    check({tag, "_lat"},  64'(cyc - t0), 64'd5);
    check({tag, "_sum"},  bus4.resp_sum, exp_sum);
    check({tag, "_cout"}, 64'(bus4.resp_cout), 64'(exp_cout));
    check({tag, "_id"},   64'(bus4.resp_id), 64'(id));
    step();
    check({tag, "_done"}, 64'(bus4.resp_valid), 64'd0);
    exp_rr = ~id;
  endtask

  initial begin
    logic [63:0] ea, eb;
    logic [64:0] model;
    logic        expg;
    logic [1:0]  pat;
    int          cnt, t0, n, gap;
    bit          got;

    vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1};
    vecs[1] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 64'h0001_0000_0001_0000, 1'b0};
    vecs[2] = '{1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_4321, 64'h0000_0000_0000_5555, 1'b0};
    vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[4] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h1234_5678_9ABC_DF00, 1'b0};
    vecs[5] = '{1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 64'h0000_0001_0000_0000, 1'b1};

    rst = 1'b1;
    bus4.req_valid = 2'b00; bus4.req_a = '0; bus4.req_b = '0; bus4.resp_ready = 1'b0;
    bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.resp_ready = 1'b0;
    exp_rr = 1'b0;
    step();
    step();
    check("rst_busy",       64'(busy4), 64'd0);
    check("rst_resp_valid", 64'(bus4.resp_valid), 64'd0);
    check("rst_resp_sum",   bus4.resp_sum[63:0], 64'd0);
    check("rst_resp_cout",  64'(bus4.resp_cout), 64'd0);
    check("rst_resp_id",    64'(bus4.resp_id), 64'd0);
    check("rst_req_ready",  64'(bus4.req_ready), 64'd0);
    rst = 1'b0;
    step();

    // directed table
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);

    // both valid continuously: grants must alternate starting from exp_rr
    bus4.req_a = {64'd10, 64'd1};
    bus4.req_b = {64'd20, 64'd2};
    bus4.req_valid  = 2'b11;
    bus4.resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus4.req_ready == 2'b00 && n < 50) begin step(); n++; end
      expg = exp_rr;
      check($sformatf("alt%0d_grant", k), 64'(bus4.req_ready), expg ? 64'd2 : 64'd1);
      step();
      wait_resp4();
      check($sformatf("alt%0d_id", k),  64'(bus4.resp_id), 64'(expg));
      check($sformatf("alt%0d_sum", k), bus4.resp_sum[63:0], expg ? 64'd30 : 64'd3);
      step();
      exp_rr = ~expg;
    end
    bus4.req_valid = 2'b00;
    step();

    // back-pressure: stall in DONE while requester 1 waits
    bus4.resp_ready = 1'b0;
    bus4.req_a = {64'd5, 64'h0123_4567_89AB_CDEF};
    bus4.req_b = {64'd6, 64'h1111_1111_1111_1111};
    bus4.req_valid = 2'b01;
    #1;
    wait_ready4(1'b0);
    check("bp_hs", 64'(bus4.req_ready), 64'd1);
    step();
    bus4.req_valid = 2'b10;
    wait_resp4();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp%0d_valid", s), 64'(bus4.resp_valid), 64'd1);
      check($sformatf("bp%0d_sum", s),   bus4.resp_sum[63:0], 64'h1234_5678_9ABC_DF00);
      check($sformatf("bp%0d_id", s),    64'(bus4.resp_id), 64'd0);
      check($sformatf("bp%0d_ready", s), 64'(bus4.req_ready), 64'd0);
      step();
    end
    check("bp_still_valid", 64'(bus4.resp_valid), 64'd1);
    bus4.resp_ready = 1'b1;
    step();
    check("bp_complete", 64'(bus4.resp_valid), 64'd0);
    check("bp_next_ready", 64'(bus4.req_ready), 64'd2);
    bus4.req_valid = 2'b00;
    step();
    check("bp_drop_not_latched", 64'(busy4), 64'd0);
    exp_rr = 1'b1;

    // reset in the second RUN cycle discards the op
    bus4.req_a = {64'h5555_5555_5555_5555, 64'd0};
    bus4.req_b = {64'h1111_1111_1111_1111, 64'd0};
    bus4.req_valid = 2'b10;
    #1;
    wait_ready4(1'b1);
    check("rr_hs", 64'(bus4.req_ready), 64'd2);
    step();
    bus4.req_valid = 2'b00;
    step();
    rst = 1'b1;
    #1;
    check("rr_busy",       64'(busy4), 64'd0);
    check("rr_resp_valid", 64'(bus4.resp_valid), 64'd0);
    check("rr_resp_sum",   bus4.resp_sum[63:0], 64'd0);
    check("rr_resp_cout",  64'(bus4.resp_cout), 64'd0);
    check("rr_resp_id",    64'(bus4.resp_id), 64'd0);
    step();
    rst = 1'b0;
    exp_rr = 1'b0;
    cnt = 0;
    for (int s = 0; s < 8; s++) begin
      if (bus4.resp_valid) cnt++;
      step();
    end
    check("rr_no_resp", 64'(cnt), 64'd0);
    run_op("rr_fresh", 1'b1, 64'h1234, 64'h4321, 64'h5555, 1'b0);

    // WORDS=1 build
    bus1.req_a = {16'h0000, 16'hFFFF};
    bus1.req_b = {16'h0000, 16'hFFFF};
    bus1.req_valid  = 2'b01;
    bus1.resp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus1.req_ready[0] && n < 50) begin step(); n++; end
    check("w1_hs", 64'(bus1.req_ready), 64'd1);
    t0 = cyc;
    step();
    bus1.req_valid = 2'b00;
    n = 0;
    while (!bus1.resp_valid && n < 50) begin step(); n++; end
    check("w1_lat",  64'(cyc - t0), 64'd2);
    check("w1_sum",  64'(bus1.resp_sum), 64'hFFFE);
    check("w1_cout", 64'(bus1.resp_cout), 64'd1);
    check("w1_id",   64'(bus1.resp_id), 64'd0);
    step();
    check("w1_done", 64'(bus1.resp_valid), 64'd0);

    // random ops against a 65-bit behavioural adder
    for (int k = 0; k < 1000; k++) begin
      bus4.req_valid = 2'b00;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      pat = 2'($urandom_range(1, 3));
      bus4.req_a = {$urandom, $urandom, $urandom, $urandom};
      bus4.req_b = {$urandom, $urandom, $urandom, $urandom};
      bus4.req_valid = pat;
      #1;
      expg = (pat == 2'b01) ? 1'b0 : (pat == 2'b10) ? 1'b1 : exp_rr;
      ea = expg ? bus4.req_a[127:64] : bus4.req_a[63:0];
      eb = expg ? bus4.req_b[127:64] : bus4.req_b[63:0];
      model = {1'b0, ea} + {1'b0, eb};
      check("rnd_grant", 64'(bus4.req_ready), expg ? 64'd2 : 64'd1);
      step();
      bus4.req_valid = 2'b00;
      got = 1'b0;
      n = 0;
      while (!got && n < 100) begin
        bus4.resp_ready = 1'($urandom_range(0, 1));
        if (bus4.resp_valid && bus4.resp_ready) got = 1'b1;
        else begin step(); n++; end
      end
      check("rnd_resp",  64'(got), 64'd1);
      check("rnd_sum",   bus4.resp_sum[63:0], model[63:0]);
      check("rnd_cout",  64'(bus4.resp_cout), 64'(model[64]));
      check("rnd_id",    64'(bus4.resp_id), 64'(expg));
      step();
      exp_rr = ~expg;
    end

    check("ready_onehot", 64'(both_rdy), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
